systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Output-side stage directly downstream of the PE grid.
- After a compute pass, it drives the grid's chain-shift enable and captures the tail byte of every row chain once per shift.
- It serialises the captured bytes onto a valid/ready byte stream with row/column tags.
- After COLS shifts the results are fully read out. Because chain heads are tied to 0, all accumulators end the drain cleared.

Parameters:
- ROWS, 4, number of row chains (1..16).
- COLS, 4, PEs per chain, equal to the number of shifts per drain (1..16).
- DATA_W, 8, accumulator/result byte width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a drain when idle.
- chain_tail  in  ROWS*DATA_W  out_c of the last PE of each row; row r occupies bits [r*DATA_W +: DATA_W].
- chain_en  out  1  to every PE chain_in_en; high exactly one cycle per shift.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accepts the byte when valid && ready.
- out_data  out  DATA_W  result byte.
- out_row  out  clog2(ROWS) (min 1)  row tag.
- out_col  out  clog2(COLS) (min 1)  column tag (grid column index).
- out_last  out  1  high with the final byte of the drain.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - chain_en, out_valid, out_last, busy, done all 0.
  - Row and column counters 0; capture buffer 0.
  - Reset mid-drain abandons the drain immediately; no further chain_en pulse is issued.
- FSM states: IDLE, LOAD, SEND, SHIFT, DONE.
- IDLE:
  - On start go to LOAD, set col_cnt=0.
  - start in any other state is ignored.
- LOAD (1 cycle):
  - Register all of chain_tail into the capture buffer and set row_cnt=0.
  - Go to SEND.
- SEND:
  - out_valid=1.
  - out_data = buffer[row_cnt], out_row = row_cnt, out_col = COLS-1-col_cnt.
  - All outputs come from registers and stay stable while valid && !ready.
  - On handshake: if row_cnt==ROWS-1 go to SHIFT, else increment row_cnt.
  - out_last = (row_cnt==ROWS-1) && (col_cnt==COLS-1).
- SHIFT (1 cycle):
  - chain_en=1, out_valid=0.
  - If col_cnt==COLS-1 go to DONE; else increment col_cnt and go to LOAD.
  - The LOAD that follows samples the value shifted in at the SHIFT edge.
- DONE (1 cycle): done=1, then go to IDLE.
- Totals: COLS chain_en pulses per drain; the last pulse clears the grid.
- Latency with out_ready held at 1:
  - start seen at edge k: LOAD in cycle k+1, first out_valid in cycle k+2.
  - Each column takes ROWS+2 cycles.
  - done in cycle k+1+COLS*(ROWS+2).
- Back-pressure: out_ready low stalls in SEND indefinitely; chain_en is never asserted while a byte is pending.
- Ready high with valid low has no effect.
- No arithmetic is performed on data; counters never wrap mid-drain.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_RELU_EN.
- When defined, LOAD treats each captured byte as two's complement and stores 0 for negative values (bit DATA_W-1 set).
- Without the macro, bytes pass unmodified.
- Tags, timing and handshake are identical in both builds.

Decomposition:
- Shared package tpu_pkg holds:
  - The drain state enum (IDLE/LOAD/SEND/SHIFT/DONE).
  - DATA_W default constant.
  - A clog2-with-minimum-1 helper function for tag widths.
- No sub-module: a single FSM with counters and a byte mux is the natural size.

Test Plan (ROWS=2, COLS=2 unless stated):
- Basic drain, out_ready=1:
  - Stimulus: chain_tail {r1=0x22, r0=0x11}, after the first shift {r1=0x44, r0=0x33}; start pulse.
  - Expected stream: (0x11,r0,c1), (0x22,r1,c1), (0x33,r0,c0), (0x44,r1,c0,last).
  - Exactly 2 chain_en pulses; done 1+2*4=9 cycles after the start edge.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles on the first byte.
  - Expected: out_data stays 0x11 with valid high, chain_en stays 0; the sequence then completes unchanged.
- Start handling: a start pulse while busy has no effect on the stream; start held high across done launches a second drain only from IDLE.
- Mid-drain reset: assert rst_n=0 during SEND of byte 2 -> next cycle all outputs 0, state IDLE, no chain_en; a new start gives a clean drain.
- RELU build:
  - Stimulus: chain_tail r0=0x80, r1=0x7F.
  - Expected with SYSTOLIC_DRAIN_RELU_EN: 0x00 and 0x7F. Expected without: 0x80 and 0x7F.
- Degenerate ROWS=1, COLS=1:
  - Expected: one byte with out_last=1, one chain_en pulse, done 4 cycles after start.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: drain FSM states, default result width and the
// tag-width helper used for row/column tag ports.
package tpu_pkg;

    localparam int DRAIN_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_SHIFT,
        S_DONE
    } drain_state_e;

    // Tag width for an index range of n entries; never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_drain.sv
// systolic_drain: reads results out of the PE grid after a compute pass.
// Each column step captures the tail byte of every row chain, streams the
// bytes out with row/column tags, then pulses chain_en once to shift the
// chains. COLS shifts empty the grid (chain heads feed zeros).
// Optional build macro SYSTOLIC_DRAIN_RELU_EN: negative captured bytes are
// stored as zero; timing and tags are unchanged.
module systolic_drain
    import tpu_pkg::*;
#(
    parameter  int ROWS   = 4,
    parameter  int COLS   = 4,
    parameter  int DATA_W = DRAIN_DATA_W,
    localparam int RW     = clog2_min1(ROWS),
    localparam int CW     = clog2_min1(COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROWS*DATA_W-1:0] chain_tail,
    output logic                   chain_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [RW-1:0]          out_row,
    output logic [CW-1:0]          out_col,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    drain_state_e                   state;
    logic [RW-1:0]                  row_cnt;
    logic [CW-1:0]                  col_cnt;
    logic [ROWS-1:0][DATA_W-1:0]    cap_buf;

    logic          last_row;
    logic          last_col;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_tag;

    // Byte conditioning applied when the chain tails are captured.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] b);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return b[DATA_W-1] ? '0 : b;
`else
        return b;
`endif
    endfunction

    assign last_row = (row_cnt == ROW_MAX);
    assign last_col = (col_cnt == COL_MAX);
    assign row_nxt  = row_cnt + RW'(1);
    // First shift exposes the far column, so tags count down.
    assign col_tag  = COL_MAX - col_cnt;
    assign busy     = (state != S_IDLE);

    // Drain FSM: capture, stream ROWS bytes, shift, repeat COLS times.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            cap_buf   <= '0;
            chain_en  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            done      <= 1'b0;
        end else begin
            chain_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col_cnt <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int r = 0; r < ROWS; r++)
                        cap_buf[r] <= relu(chain_tail[r*DATA_W +: DATA_W]);
                    row_cnt   <= '0;
                    out_valid <= 1'b1;
                    out_data  <= relu(chain_tail[DATA_W-1:0]);
                    out_row   <= '0;
                    out_col   <= col_tag;
                    out_last  <= (ROWS == 1) && last_col;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (last_row) begin
                            // chain_en only after the last byte is taken
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            chain_en  <= 1'b1;
                            state     <= S_SHIFT;
                        end else begin
                            row_cnt  <= row_nxt;
                            out_data <= cap_buf[row_nxt];
                            out_row  <= row_nxt;
                            out_last <= (row_nxt == ROW_MAX) && last_col;
                        end
                    end
                end
                S_SHIFT: begin
                    if (last_col) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                        state   <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: a 2x2 instance driven by a behavioural grid
// model, plus a degenerate 1x1 instance.
module tb_systolic_drain;

    localparam int R = 2;
    localparam int C = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 2x2 instance
    logic           start = 1'b0;
    logic           out_ready = 1'b0;
    logic [R*W-1:0] chain_tail;
    logic           chain_en, out_valid, out_last, busy, done;
    logic [W-1:0]   out_data;
    logic [0:0]     out_row, out_col;

    // 1x1 instance
    logic           start_b = 1'b0;
    logic           ready_b = 1'b0;
    logic [W-1:0]   tail_b;
    logic           chain_en_b, valid_b, last_b, busy_b, done_b;
    logic [W-1:0]   data_b;
    logic [0:0]     row_b, col_b;

    systolic_drain #(.ROWS(R), .COLS(C), .DATA_W(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .chain_tail(chain_tail),
        .chain_en(chain_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .done(done)
    );

    systolic_drain #(.ROWS(1), .COLS(1), .DATA_W(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .chain_tail(tail_b),
        .chain_en(chain_en_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_data(data_b), .out_row(row_b), .out_col(col_b),
        .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PE grid: each row is a chain shifting toward the tail,
    // head fed with zero.
    logic [W-1:0] grid      [R][C];
    logic [W-1:0] load_vals [R][C];
    logic         load_req = 1'b0;
    logic [W-1:0] gb;
    logic [W-1:0] lv_b = '0;
    logic         load_req_b = 1'b0;

    always @(posedge clk) begin
        if (load_req) grid <= load_vals;
        else if (chain_en) begin
            for (int r = 0; r < R; r++) begin
                for (int c = C - 1; c > 0; c--) grid[r][c] <= grid[r][c-1];
                grid[r][0] <= '0;
            end
        end
        if (load_req_b) gb <= lv_b;
        else if (chain_en_b) gb <= '0;
    end

    always_comb begin
        chain_tail = '0;
        for (int r = 0; r < R; r++) chain_tail[r*W +: W] = grid[r][C-1];
    end
    assign tail_b = gb;

    function automatic int pk(int d, int r, int c, int l);
        return d | (r << 8) | (c << 12) | (l << 16);
    endfunction

    function automatic int relu_m(int b);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return (b >= 128) ? 0 : b;
`else
        return b;
`endif
    endfunction

    // Monitor: accepted bytes, chain_en cycles, done pulses.
    int q_a[$];
    int q_b[$];
    int en_cnt = 0, done_cnt = 0, done_cyc = -1;
    int en_cnt_b = 0, done_cnt_b = 0, done_cyc_b = -1;

    always @(negedge clk) begin
        if (out_valid && out_ready)
            q_a.push_back(pk(int'(out_data), int'(out_row), int'(out_col), int'(out_last)));
        if (chain_en) en_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (valid_b && ready_b)
            q_b.push_back(pk(int'(data_b), int'(row_b), int'(col_b), int'(last_b)));
        if (chain_en_b) en_cnt_b++;
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_grid();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic rand_vals();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) load_vals[r][c] = W'($urandom_range(0, 255));
    endtask

    // Expected stream: shift s exposes grid column C-1-s at every tail.
    task automatic make_exp(output int e[$]);
        e = {};
        for (int s = 0; s < C; s++)
            for (int r = 0; r < R; r++)
                e.push_back(pk(relu_m(int'(load_vals[r][C-1-s])), r, C - 1 - s,
                               int'(s == C - 1 && r == R - 1)));
    endtask

    task automatic check_stream(input string tag, input int base, input int e[$]);
        chk({tag, ":count"}, q_a.size() - base, e.size());
        for (int i = 0; i < e.size(); i++)
            if (base + i < q_a.size()) chk({tag, ":byte"}, q_a[base + i], e[i]);
    endtask

    // Run one drain on the 2x2 instance. mode 0: ready high; 1: random ready.
    // extra_start: cycle index at which a stray start pulse is issued (-1 none).
    task automatic run_drain(input string tag, input int mode, input int extra_start,
                             output int k);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        k = cyc;
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            start = (i == extra_start);
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            if (done_cnt > d0) break;
        end
        start = 1'b0;
        chk({tag, ":finished"}, done_cnt - d0, 1);
    endtask

    initial begin
        int e[$];
        int base, en0, k, d0;

        // reset state
        repeat (3) step();
        chk("rst:chain_en", chain_en, 0);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:out_last", out_last, 0);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:busy_b", busy_b, 0);
        rst_n = 1'b1;
        step();

        // basic drain with fixed bytes
        load_vals[0][1] = 8'h11; load_vals[1][1] = 8'h22;
        load_vals[0][0] = 8'h33; load_vals[1][0] = 8'h44;
        load_grid();
        make_exp(e);
        base = q_a.size();
        en0 = en_cnt;
        run_drain("basic", 0, -1, k);
        check_stream("basic", base, e);
        chk("basic:chain_en_pulses", en_cnt - en0, C);
        chk("basic:done_latency", done_cyc - k, C * (R + 2));
        chk("basic:grid_cleared", {grid[0][1], grid[1][1], grid[0][0], grid[1][0]}, 0);

        // back-pressure on the first byte
        load_grid();
        make_exp(e);
        base = q_a.size();
        en0 = en_cnt;
        d0 = done_cnt;
        start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp:valid", out_valid, 1);
            chk("bp:data", out_data, 8'h11);
            chk("bp:chain_en", chain_en, 0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 50 && done_cnt == d0; i++) step();
        check_stream("bp", base, e);
        chk("bp:chain_en_pulses", en_cnt - en0, C);

        // stray start while busy
        rand_vals();
        load_grid();
        make_exp(e);
        base = q_a.size();
        d0 = done_cnt;
        run_drain("busy_start", 0, 3, k);
        check_stream("busy_start", base, e);
        repeat (3) step();
        chk("busy_start:no_relaunch", busy, 0);
        chk("busy_start:one_done", done_cnt - d0, 1);

        // start held high across done
        rand_vals();
        load_grid();
        make_exp(e);
        base = q_a.size();
        d0 = done_cnt;
        start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50 && done_cnt == d0; i++) step();
        chk("held:idle_gap", busy, 0);
        step();
        start = 1'b0;
        chk("held:relaunch", busy, 1);
        for (int i = 0; i < 50 && done_cnt < d0 + 2; i++) step();
        chk("held:two_dones", done_cnt - d0, 2);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) load_vals[r][c] = '0;
        begin
            int e2[$];
            make_exp(e2);
            e = {e, e2};
        end
        check_stream("held", base, e);

        // mid-drain reset during the second byte
        rand_vals();
        load_grid();
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_row == 1'b1); i++) step();
        chk("mrst:reached_byte2", out_valid && out_row == 1'b1, 1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst:chain_en", chain_en, 0);
        chk("mrst:valid", out_valid, 0);
        chk("mrst:last", out_last, 0);
        chk("mrst:busy", busy, 0);
        chk("mrst:done", done, 0);
        chk("mrst:data", out_data, 0);
        chk("mrst:tags", {out_row, out_col}, 0);
        rst_n = 1'b1;
        en0 = en_cnt;
        repeat (4) step();
        chk("mrst:no_shift", en_cnt - en0, 0);
        chk("mrst:idle", busy, 0);
        rand_vals();
        load_grid();
        make_exp(e);
        base = q_a.size();
        run_drain("mrst_clean", 0, -1, k);
        check_stream("mrst_clean", base, e);

        // RELU boundary bytes
        rand_vals();
        load_vals[0][C-1] = 8'h80;
        load_vals[1][C-1] = 8'h7F;
        load_grid();
        make_exp(e);
        base = q_a.size();
        run_drain("relu", 0, -1, k);
        check_stream("relu", base, e);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        if (q_a.size() > base) chk("relu:neg_byte", q_a[base] & 32'hFF, 8'h00);
`else
        if (q_a.size() > base) chk("relu:neg_byte", q_a[base] & 32'hFF, 8'h80);
`endif
        if (q_a.size() > base + 1) chk("relu:pos_byte", q_a[base + 1] & 32'hFF, 8'h7F);

        // random data with random back-pressure
        for (int t = 0; t < 6; t++) begin
            rand_vals();
            load_grid();
            make_exp(e);
            base = q_a.size();
            en0 = en_cnt;
            run_drain("rand", 1, -1, k);
            check_stream("rand", base, e);
            chk("rand:chain_en_pulses", en_cnt - en0, C);
        end

        // degenerate 1x1 instance
        lv_b = W'($urandom_range(0, 255));
        load_req_b = 1'b1;
        step();
        load_req_b = 1'b0;
        base = q_b.size();
        en0 = en_cnt_b;
        d0 = done_cnt_b;
        start_b = 1'b1; ready_b = 1'b1;
        step();
        k = cyc;
        start_b = 1'b0;
        for (int i = 0; i < 20 && done_cnt_b == d0; i++) step();
        chk("deg:done", done_cnt_b - d0, 1);
        chk("deg:latency", done_cyc_b - k, 3);
        chk("deg:chain_en_pulses", en_cnt_b - en0, 1);
        chk("deg:count", q_b.size() - base, 1);
        if (q_b.size() > base)
            chk("deg:byte", q_b[base], pk(relu_m(int'(lv_b)), 0, 0, 1));
        chk("deg:cleared", gb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
